gpio_serial_loader: RTL and testbench

- Controller that sequences the GPIO pad-configuration serial chain.
- Holds one PAD_CTRL_BITS-wide configuration word per GPIO.
- On a start request it shifts all words out MSB-first, farthest block first, then pulses serial_load so every control block in the chain latches its word at the same time.
- Sits in housekeeping between the management register interface and the first control block of the chain.

---
 rtl/gpio_cfg_pkg.sv | 29 ++
 rtl/gpio_cfg_regfile.sv | 66 ++++++
 rtl/gpio_serial_loader.sv | 136 +++++++++++++
 tb/tb_gpio_serial_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad-configuration serial chain:
// configuration word width, field offsets inside a word, and the loader
// FSM state encoding.
package gpio_cfg_pkg;

    localparam int PAD_CTRL_BITS = 13;

    // Field offsets inside one pad configuration word
    localparam int MGMT_EN_OFS = 0;
    localparam int OEB_OFS     = 1;
    localparam int HLDH_OFS    = 2;
    localparam int INP_DIS_OFS = 3;
    localparam int MOD_SEL_OFS = 4;
    localparam int AN_EN_OFS   = 5;
    localparam int AN_SEL_OFS  = 6;
    localparam int AN_POL_OFS  = 7;
    localparam int SLOW_OFS    = 8;
    localparam int TRIP_OFS    = 9;
    localparam int DM_OFS      = 10;
    localparam int DM_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2,
        ST_GUARD = 2'd3
    } loader_state_t;

endpackage

// File: rtl/gpio_cfg_regfile.sv
// Pad configuration register file: NUM_IO words of PAD_CTRL_BITS each.
// Ports:
//   serial_clock, resetn  : clock, asynchronous active-low reset
//   gpio_defaults         : per-word reset values, word i at [i*W +: W]
//   cfg_we/cfg_sel/cfg_wdata : write port (accepted only when wr_allow)
//   wr_allow              : high while the loader is idle
//   cfg_rdata             : combinational readback of word cfg_sel (0 if out of range)
//   cfg_err               : one-cycle pulse after a rejected write
//   sh_sel / sh_word      : second read port used by the shifter
module gpio_cfg_regfile
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_IO        = 19,
    parameter int PAD_CTRL_BITS = gpio_cfg_pkg::PAD_CTRL_BITS
) (
    input  logic                              serial_clock,
    input  logic                              resetn,
    input  logic [NUM_IO*PAD_CTRL_BITS-1:0]   gpio_defaults,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_IO)-1:0]         cfg_sel,
    input  logic [PAD_CTRL_BITS-1:0]          cfg_wdata,
    input  logic                              wr_allow,
    output logic [PAD_CTRL_BITS-1:0]          cfg_rdata,
    output logic                              cfg_err,
    input  logic [$clog2(NUM_IO)-1:0]         sh_sel,
    output logic [PAD_CTRL_BITS-1:0]          sh_word
);

    logic [PAD_CTRL_BITS-1:0] cfg_q [NUM_IO];
    logic [PAD_CTRL_BITS-1:0] cfg_d [NUM_IO];
    logic                     cfg_err_q;
    logic                     cfg_err_d;
    logic                     sel_ok;

    // cfg_sel can address past NUM_IO when NUM_IO is not a power of two
    assign sel_ok = (32'(cfg_sel) < 32'(NUM_IO));

    always_comb begin
        cfg_d     = cfg_q;
        cfg_err_d = 1'b0;
        if (cfg_we) begin
            if (wr_allow && sel_ok) begin
                cfg_d[cfg_sel] = cfg_wdata;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_IO; i++) begin
                cfg_q[i] <= gpio_defaults[i*PAD_CTRL_BITS +: PAD_CTRL_BITS];
            end
            cfg_err_q <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_rdata = sel_ok ? cfg_q[cfg_sel] : '0;
    assign cfg_err   = cfg_err_q;
    assign sh_word   = cfg_q[sh_sel];

endmodule

// File: rtl/gpio_serial_loader.sv
// Sequencer for the GPIO pad-configuration serial chain. On xfer_start it
// shifts every configuration word out MSB-first, farthest block first, then
// pulses serial_load so all chain blocks latch their word together.
// Ports:
//   serial_clock, resetn : chain clock (FSM on posedge, chain outputs on
//                          negedge), asynchronous active-low reset
//   gpio_defaults        : reset values of the configuration array
//   cfg_we/cfg_sel/cfg_wdata/cfg_rdata/cfg_err : management access port
//   xfer_start           : level-sampled transfer request
//   busy / done          : transfer in progress / one-cycle completion pulse
//   serial_data_out      : serial data to block 0 of the chain
//   serial_load          : load strobe to the chain
module gpio_serial_loader
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_IO        = 19,
    parameter int PAD_CTRL_BITS = gpio_cfg_pkg::PAD_CTRL_BITS
) (
    input  logic                              serial_clock,
    input  logic                              resetn,
    input  logic [NUM_IO*PAD_CTRL_BITS-1:0]   gpio_defaults,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_IO)-1:0]         cfg_sel,
    input  logic [PAD_CTRL_BITS-1:0]          cfg_wdata,
    output logic [PAD_CTRL_BITS-1:0]          cfg_rdata,
    output logic                              cfg_err,
    input  logic                              xfer_start,
    output logic                              busy,
    output logic                              done,
    output logic                              serial_data_out,
    output logic                              serial_load
);

    localparam int SEL_W = $clog2(NUM_IO);
    localparam int BIT_W = $clog2(PAD_CTRL_BITS);

    loader_state_t            state_q, state_d;
    logic [SEL_W-1:0]         io_cnt_q, io_cnt_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic                     done_q, done_d;
    logic                     sdo_q, sdo_d;
    logic                     load_q, load_d;
    logic [PAD_CTRL_BITS-1:0] sh_word;

    gpio_cfg_regfile #(
        .NUM_IO        (NUM_IO),
        .PAD_CTRL_BITS (PAD_CTRL_BITS)
    ) u_regfile (
        .serial_clock  (serial_clock),
        .resetn        (resetn),
        .gpio_defaults (gpio_defaults),
        .cfg_we        (cfg_we),
        .cfg_sel       (cfg_sel),
        .cfg_wdata     (cfg_wdata),
        .wr_allow      (state_q == ST_IDLE),
        .cfg_rdata     (cfg_rdata),
        .cfg_err       (cfg_err),
        .sh_sel        (io_cnt_q),
        .sh_word       (sh_word)
    );

    always_comb begin
        state_d   = state_q;
        io_cnt_d  = io_cnt_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer_start) begin
                    state_d   = ST_SHIFT;
                    io_cnt_d  = SEL_W'(NUM_IO - 1);
                    bit_cnt_d = BIT_W'(PAD_CTRL_BITS - 1);
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = BIT_W'(PAD_CTRL_BITS - 1);
                    if (io_cnt_q == '0) begin
                        state_d = ST_LOAD;
                    end else begin
                        io_cnt_d = io_cnt_q - 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            io_cnt_q  <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            io_cnt_q  <= io_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

    // Chain outputs change on negedge so they are stable half a cycle on
    // either side of the posedge at which the chain blocks sample them.
    always_comb begin
        sdo_d  = (state_q == ST_SHIFT) ? sh_word[bit_cnt_q] : 1'b0;
        load_d = (state_q == ST_LOAD);
    end

    always_ff @(negedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            sdo_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            sdo_q  <= sdo_d;
            load_q <= load_d;
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign serial_data_out = sdo_q;
    assign serial_load     = load_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Self-checking bench for gpio_serial_loader: a 2-block instance driving a
// model chain, and a default 19-block instance.
module tb_gpio_serial_loader;
    import gpio_cfg_pkg::*;

    localparam int W   = PAD_CTRL_BITS;
    localparam int T2  = 2 * W;
    localparam int T19 = 19 * W;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // 2-block instance
    logic [2*W-1:0]  defaults2;
    logic            we2, start2, err2, busy2, done2, sdo2, ld2;
    logic [0:0]      sel2;
    logic [W-1:0]    wd2, rd2;
    // 19-block instance
    logic [19*W-1:0] defaults19;
    logic            we19, start19, err19, busy19, done19, sdo19, ld19;
    logic [4:0]      sel19;
    logic [W-1:0]    wd19, rd19;

    gpio_serial_loader #(.NUM_IO(2), .PAD_CTRL_BITS(W)) dut2 (
        .serial_clock(clk), .resetn(resetn), .gpio_defaults(defaults2),
        .cfg_we(we2), .cfg_sel(sel2), .cfg_wdata(wd2), .cfg_rdata(rd2),
        .cfg_err(err2), .xfer_start(start2), .busy(busy2), .done(done2),
        .serial_data_out(sdo2), .serial_load(ld2)
    );

    gpio_serial_loader #(.NUM_IO(19), .PAD_CTRL_BITS(W)) dut19 (
        .serial_clock(clk), .resetn(resetn), .gpio_defaults(defaults19),
        .cfg_we(we19), .cfg_sel(sel19), .cfg_wdata(wd19), .cfg_rdata(rd19),
        .cfg_err(err19), .xfer_start(start19), .busy(busy19), .done(done19),
        .serial_data_out(sdo19), .serial_load(ld19)
    );

    // Two chain blocks behind dut2: shift on posedge, latch on serial_load
    logic [W-1:0] b0_sh, b1_sh, b0_lat, b1_lat;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b0_sh  <= '0;
            b1_sh  <= '0;
            b0_lat <= defaults2[0 +: W];
            b1_lat <= defaults2[W +: W];
        end else begin
            b0_sh <= {b0_sh[W-2:0], sdo2};
            b1_sh <= {b1_sh[W-2:0], b0_sh[W-1]};
            if (ld2) begin
                b0_lat <= b0_sh;
                b1_lat <= b1_sh;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp2  [2];
    logic [W-1:0] exp19 [19];

    typedef struct {
        bit           dut;     // 0: dut2, 1: dut19
        bit           we;
        logic [4:0]   sel;
        logic [W-1:0] wdata;
        logic [W-1:0] exp_rd;
        bit           exp_err;
    } vec_t;
    vec_t vecs [11];

    function automatic logic [W-1:0] def19(int i);
        return W'((i * 311) ^ 2650);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_models();
        for (int i = 0; i < 2; i++) exp2[i] = defaults2[i*W +: W];
        for (int i = 0; i < 19; i++) exp19[i] = def19(i);
    endtask

    // Full dut2 transfer with per-cycle checks. j counts posedges from P0.
    task automatic xfer2(input bit inject_we, input bit inject_start, input int abort_at,
                         input bit co_write, input logic [W-1:0] co_data, input string tag);
        logic [T2-1:0] stream;
        @(posedge clk); #2;
        if (co_write) begin
            we2 = 1'b1; sel2 = 1'b0; wd2 = co_data;
            exp2[0] = co_data;
        end
        start2 = 1'b1;
        stream = {exp2[1], exp2[0]};
        for (int j = 0; j <= T2 + 3; j++) begin
            @(posedge clk); #2;
            check($sformatf("%s busy j=%0d", tag, j), 32'(busy2), 32'(j < T2 + 2));
            check($sformatf("%s done j=%0d", tag, j), 32'(done2), 32'(j == T2 + 2));
            check($sformatf("%s cfg_err j=%0d", tag, j), 32'(err2), 32'(inject_we && j == 4));
            if (j == abort_at) begin
                start2 = 1'b0;
                resetn = 1'b0;
                #1;
                check($sformatf("%s abort sdo", tag), 32'(sdo2), 32'd0);
                check($sformatf("%s abort load", tag), 32'(ld2), 32'd0);
                check($sformatf("%s abort busy", tag), 32'(busy2), 32'd0);
                @(negedge clk); #2;
                check($sformatf("%s abort load after negedge", tag), 32'(ld2), 32'd0);
                resetn = 1'b1;
                reset_models();
                return;
            end
            we2    = inject_we && (j == 3);
            sel2   = 1'b0;
            wd2    = 13'h1FFF;
            start2 = inject_start && (j == 5);
            @(negedge clk); #2;
            check($sformatf("%s sdo j=%0d", tag, j), 32'(sdo2),
                  32'((j < T2) ? stream[T2-1-j] : 1'b0));
            check($sformatf("%s load j=%0d", tag, j), 32'(ld2), 32'(j == T2));
        end
    endtask

    task automatic check_latches(input string tag);
        check({tag, " block0"}, 32'(b0_lat), 32'(exp2[0]));
        check({tag, " block1"}, 32'(b1_lat), 32'(exp2[1]));
    endtask

    task automatic wr2(input logic sel, input logic [W-1:0] data);
        @(posedge clk); #2;
        we2 = 1'b1; sel2 = sel; wd2 = data;
        @(posedge clk); #2;
        we2 = 1'b0;
        check("wr2 cfg_err", 32'(err2), 32'd0);
        exp2[sel] = data;
    endtask

    initial begin
        defaults2 = {13'h1C00, 13'h0403};
        for (int i = 0; i < 19; i++) defaults19[i*W +: W] = def19(i);
        reset_models();
        resetn = 1'b0;
        we2 = 0; sel2 = 0; wd2 = '0; start2 = 0;
        we19 = 0; sel19 = '0; wd19 = '0; start19 = 0;

        vecs[0]  = '{0, 0, 5'd0,  13'h0000, 13'h0403, 0};
        vecs[1]  = '{0, 0, 5'd1,  13'h0000, 13'h1C00, 0};
        vecs[2]  = '{1, 0, 5'd0,  13'h0000, def19(0), 0};
        vecs[3]  = '{1, 0, 5'd18, 13'h0000, def19(18), 0};
        vecs[4]  = '{0, 1, 5'd0,  13'h1ABC, 13'h1ABC, 0};
        vecs[5]  = '{0, 1, 5'd1,  13'h0555, 13'h0555, 0};
        vecs[6]  = '{1, 1, 5'd19, 13'h1234, 13'h0000, 1};
        vecs[7]  = '{1, 1, 5'd31, 13'h0FFF, 13'h0000, 1};
        vecs[8]  = '{1, 1, 5'd18, 13'h1357, 13'h1357, 0};
        vecs[9]  = '{1, 0, 5'd19, 13'h0000, 13'h0000, 0};
        vecs[10] = '{0, 0, 5'd0,  13'h0000, 13'h1ABC, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("reset sdo2", 32'(sdo2), 32'd0);
        check("reset load2", 32'(ld2), 32'd0);
        check("reset busy2", 32'(busy2), 32'd0);
        check("reset done2", 32'(done2), 32'd0);
        check("reset err2", 32'(err2), 32'd0);
        check("reset busy19", 32'(busy19), 32'd0);
        check("reset load19", 32'(ld19), 32'd0);
        check("reset word0 fields", 32'(rd2),
              32'((13'd1 << DM_OFS) | (13'd1 << OEB_OFS) | (13'd1 << MGMT_EN_OFS)));
        @(negedge clk); #2;
        resetn = 1'b1;

        // Register access vectors
        foreach (vecs[i]) begin
            @(posedge clk); #2;
            if (!vecs[i].dut) begin
                we2 = vecs[i].we; sel2 = vecs[i].sel[0]; wd2 = vecs[i].wdata;
            end else begin
                we19 = vecs[i].we; sel19 = vecs[i].sel; wd19 = vecs[i].wdata;
            end
            @(posedge clk); #2;
            we2 = 1'b0; we19 = 1'b0;
            #1;
            if (!vecs[i].dut) begin
                check($sformatf("vec%0d cfg_err", i), 32'(err2), 32'(vecs[i].exp_err));
                check($sformatf("vec%0d cfg_rdata", i), 32'(rd2), 32'(vecs[i].exp_rd));
                if (vecs[i].we && !vecs[i].exp_err) exp2[vecs[i].sel[0]] = vecs[i].wdata;
            end else begin
                check($sformatf("vec%0d cfg_err", i), 32'(err19), 32'(vecs[i].exp_err));
                check($sformatf("vec%0d cfg_rdata", i), 32'(rd19), 32'(vecs[i].exp_rd));
                if (vecs[i].we && !vecs[i].exp_err) exp19[vecs[i].sel] = vecs[i].wdata;
            end
        end

        // Plain transfer: 0x0555 then 0x1ABC
        xfer2(0, 0, -1, 0, '0, "xfer");
        check_latches("xfer");

        // Rejected write and ignored restart during the transfer
        xfer2(1, 1, -1, 0, '0, "busy-write");
        sel2 = 1'b0; #1;
        check("busy-write word0 kept", 32'(rd2), 32'(exp2[0]));
        check_latches("busy-write");

        // Write in the same edge as the accepted start is shifted out
        xfer2(0, 0, -1, 1, 13'h0F0F, "co-write");
        check_latches("co-write");

        // Back-to-back: start held high gives one IDLE cycle between transfers
        @(posedge clk); #2;
        start2 = 1'b1;
        for (int j = 0; j <= T2 + 4; j++) begin
            @(posedge clk); #2;
            check($sformatf("b2b busy j=%0d", j), 32'(busy2), 32'((j < T2 + 2) || (j >= T2 + 3)));
            check($sformatf("b2b done j=%0d", j), 32'(done2), 32'(j == T2 + 2));
        end
        start2 = 1'b0;
        repeat (T2 + 4) @(posedge clk);
        #2;
        check("b2b idle", 32'(busy2), 32'd0);
        check_latches("b2b");

        // Default-size transfer: load rises at N247
        @(posedge clk); #2;
        start19 = 1'b1;
        for (int j = 0; j <= T19 + 2; j++) begin
            @(posedge clk); #2;
            start19 = 1'b0;
            check($sformatf("x19 busy j=%0d", j), 32'(busy19), 32'(j < T19 + 2));
            @(negedge clk); #2;
            check($sformatf("x19 sdo j=%0d", j), 32'(sdo19),
                  32'((j < T19) ? exp19[18 - j / W][W - 1 - j % W] : 1'b0));
            check($sformatf("x19 load j=%0d", j), 32'(ld19), 32'(j == T19));
        end

        // Reset at shift 10, then clean restart with new data
        xfer2(0, 0, 10, 0, '0, "abort");
        sel2 = 1'b0; #1;
        check("abort word0 default", 32'(rd2), 32'h0403);
        sel2 = 1'b1; #1;
        check("abort word1 default", 32'(rd2), 32'h1C00);
        check_latches("abort chain defaults");
        wr2(1'b0, 13'h1234);
        wr2(1'b1, 13'h0ACE);
        xfer2(0, 0, -1, 0, '0, "restart");
        check_latches("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
